// File: rtl/mandelbrot_shader.sv
// mandelbrot_shader: fixed-point escape-time Mandelbrot pixel worker on the renderer's start/done job protocol.
// Optional build macro MANDEL_TIMER_ANIM_EN offsets the red channel by the latched timer[7:0].
module mandelbrot_shader #(
  parameter int WIDTH      = 1280,
  parameter int HEIGHT     = 720,
  parameter int BITS       = 32,
  parameter int FRAC       = 16,
  parameter int ZOOM_SHIFT = 8,
  parameter int MAX_ITER   = 64
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      start_in,
  input  logic [$clog2(WIDTH)-1:0]  curr_x,
  input  logic [$clog2(HEIGHT)-1:0] curr_y,
  input  logic [31:0]               timer,
  output logic                      pixel_done,
  output logic [23:0]               color_out,
  output logic [$clog2(WIDTH)-1:0]  out_x,
  output logic [$clog2(HEIGHT)-1:0] out_y,
  output logic                      busy_out
);
  localparam int XW     = $clog2(WIDTH);
  localparam int YW     = $clog2(HEIGHT);
  localparam int CSHIFT = FRAC - ZOOM_SHIFT;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ITER = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [7:0]            ITER_CAP = 8'(MAX_ITER);
  localparam logic signed [BITS:0]  ESC_LIM  = (BITS+1)'(4) <<< FRAC;

  logic [1:0]             r_state;
  logic [XW-1:0]          r_x;
  logic [YW-1:0]          r_y;
  logic signed [BITS-1:0] r_cr, r_ci, r_zr, r_zi;
  logic [7:0]             r_iter;
  logic                   r_pixel_done;
  logic [23:0]            r_color;
  logic [XW-1:0]          r_out_x;
  logic [YW-1:0]          r_out_y;
  logic                   r_busy;

  logic signed [BITS-1:0]   w_cr_init, w_ci_init;
  logic signed [2*BITS-1:0] w_zr2_full, w_zi2_full, w_zri_full;
  logic signed [BITS-1:0]   w_zr2, w_zi2, w_zri;
  logic signed [BITS:0]     w_mag;
  logic                     w_escape;
  logic [7:0]               w_toff;
  logic [7:0]               w_red, w_grn, w_blu;
  logic                     w_unused;

  // Pixel pitch is 2^-ZOOM_SHIFT, centred on the middle of the frame.
  assign w_cr_init = (BITS'(curr_x) - BITS'(WIDTH / 2)) << CSHIFT;
  assign w_ci_init = (BITS'(curr_y) - BITS'(HEIGHT / 2)) << CSHIFT;

  assign w_zr2_full = (2*BITS)'(r_zr) * (2*BITS)'(r_zr);
  assign w_zi2_full = (2*BITS)'(r_zi) * (2*BITS)'(r_zi);
  assign w_zri_full = (2*BITS)'(r_zr) * (2*BITS)'(r_zi);
  assign w_zr2      = w_zr2_full[FRAC +: BITS];
  assign w_zi2      = w_zi2_full[FRAC +: BITS];
  assign w_zri      = w_zri_full[FRAC +: BITS];

  assign w_mag    = {w_zr2[BITS-1], w_zr2} + {w_zi2[BITS-1], w_zi2};
  assign w_escape = (w_mag > ESC_LIM);

`ifdef MANDEL_TIMER_ANIM_EN
  logic [7:0] r_toff;
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_toff <= 8'd0;
    end else if (r_state == S_IDLE && start_in) begin
      r_toff <= timer[7:0];
    end
  end
  assign w_toff = r_toff;
`else
  assign w_toff = 8'd0;
`endif

  assign w_red = (r_iter << 2) + w_toff;
  assign w_grn = r_iter << 3;
  assign w_blu = 8'hFF - (r_iter << 2);

  assign w_unused = ^{w_zr2_full, w_zi2_full, w_zri_full, timer};

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state      <= S_IDLE;
      r_x          <= '0;
      r_y          <= '0;
      r_cr         <= '0;
      r_ci         <= '0;
      r_zr         <= '0;
      r_zi         <= '0;
      r_iter       <= '0;
      r_pixel_done <= 1'b0;
      r_color      <= '0;
      r_out_x      <= '0;
      r_out_y      <= '0;
      r_busy       <= 1'b0;
    end else begin
      r_pixel_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start_in) begin
            r_x     <= curr_x;
            r_y     <= curr_y;
            r_cr    <= w_cr_init;
            r_ci    <= w_ci_init;
            r_zr    <= '0;
            r_zi    <= '0;
            r_iter  <= '0;
            r_busy  <= 1'b1;
            r_state <= S_ITER;
          end
        end
        S_ITER: begin
          // Cap is checked before escape, and both before the update.
          if (r_iter == ITER_CAP || w_escape) begin
            r_color      <= (r_iter == ITER_CAP) ? 24'h000000 : {w_red, w_grn, w_blu};
            r_out_x      <= r_x;
            r_out_y      <= r_y;
            r_pixel_done <= 1'b1;
            r_busy       <= 1'b0;
            r_state      <= S_DONE;
          end else begin
            r_zr   <= w_zr2 - w_zi2 + r_cr;
            r_zi   <= (w_zri <<< 1) + r_ci;
            r_iter <= r_iter + 8'd1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign pixel_done = r_pixel_done;
  assign color_out  = r_color;
  assign out_x      = r_out_x;
  assign out_y      = r_out_y;
  assign busy_out   = r_busy;

endmodule
